// File: rtl/jt9346_ctrl.sv
// Host-side command master for a 93C46-style (x16) serial EEPROM: frames one
// parallel request onto cs/sclk/di, captures read data and polls write completion.
`timescale 1ns/1ps
module jt9346_ctrl #(
  parameter int unsigned CLKDIV  = 4,
  parameter int unsigned CSGAP   = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [5:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sclk,
  output logic        cs,
  output logic        di,
  input  logic        sdo
);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;
  localparam logic [2:0] OP_ERAL  = 3'd5;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [8:0]  PH_HALF   = 9'(CLKDIV);
  localparam logic [8:0]  PH_LAST   = 9'(2 * CLKDIV - 1);
  localparam logic [31:0] CSUP_LAST = 32'(CLKDIV - 1);
  localparam logic [31:0] GAP_LAST  = 32'(CSGAP - 1);
  localparam logic [31:0] POLL_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CSUP, ST_SHIFT, ST_RDATA, ST_WDATA, ST_GAP, ST_POLL, ST_END
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] cnt_q, cnt_d;
  logic [8:0]  ph_q, ph_d;
  logic [4:0]  bit_q, bit_d;
  logic [24:0] sh_q, sh_d;
  logic [15:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic        rsp_valid_d, rsp_err_d;
  logic [15:0] rsp_rdata_d;
  logic        shifting, per_end;

  // Start bit, 2-bit opcode and 6 address bits; x bits of the extended ops are 0.
  function automatic logic [8:0] frame_hdr(input logic [2:0] op, input logic [5:0] a);
    case (op)
      OP_READ:  frame_hdr = {3'b110, a};
      OP_WRITE: frame_hdr = {3'b101, a};
      OP_ERASE: frame_hdr = {3'b111, a};
      OP_EWEN:  frame_hdr = 9'b100_110000;
      OP_EWDS:  frame_hdr = 9'b100_000000;
      OP_ERAL:  frame_hdr = 9'b100_100000;
      OP_WRAL:  frame_hdr = 9'b100_010000;
      default:  frame_hdr = '0;
    endcase
  endfunction

  assign shifting  = (state_q == ST_SHIFT) || (state_q == ST_RDATA) || (state_q == ST_WDATA);
  assign per_end   = (ph_q == PH_LAST);
  assign req_ready = (state_q == ST_IDLE) && !rsp_valid;
  assign sclk      = shifting && (ph_q >= PH_HALF);
  assign cs        = shifting || (state_q == ST_CSUP) || (state_q == ST_POLL);
  assign di        = ((state_q == ST_SHIFT) || (state_q == ST_WDATA)) && sh_q[24];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;

    if (shifting) ph_d = per_end ? '0 : ph_q + 9'd1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = req_op;
          err_d = 1'b0;
          rd_d  = '0;
          cnt_d = '0;
          ph_d  = '0;
          bit_d = '0;
          sh_d  = {frame_hdr(req_op, req_addr), req_wdata};
          if (req_op == OP_RSVD) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_CSUP;
          end
        end
      end
      ST_CSUP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == CSUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (per_end) begin
          sh_d  = {sh_q[23:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd8) begin
            bit_d = '0;
            cnt_d = '0;
            case (op_q)
              OP_READ:            state_d = ST_RDATA;
              OP_WRITE, OP_WRAL:  state_d = ST_WDATA;
              OP_ERASE, OP_ERAL:  state_d = ST_GAP;
              default:            state_d = ST_END;
            endcase
          end
        end
      end
      ST_RDATA: begin
        // Dummy 0 follows A0 inside SHIFT, so every sample here is a data bit.
        if (per_end) begin
          rd_d  = {rd_q[14:0], sdo};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd15) begin
            bit_d   = '0;
            cnt_d   = '0;
            state_d = ST_END;
          end
        end
      end
      ST_WDATA: begin
        if (per_end) begin
          sh_d  = {sh_q[23:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd15) begin
            bit_d   = '0;
            cnt_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        cnt_d = cnt_q + 32'd1;
        if (sdo) begin
          cnt_d   = '0;
          state_d = ST_END;
        end else if (cnt_q == POLL_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_END;
        end
      end
      ST_END: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d       = '0;
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (op_q == OP_READ) ? rd_q : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_jt9346_ctrl.sv
// Bench for jt9346_ctrl: behavioural serial EEPROM on the pins, a word-level
// reference memory predicting every response, and a queue-based response monitor.
`timescale 1ns/1ps
module tb_jt9346_ctrl;
  localparam int unsigned CLKDIV  = 4;
  localparam int unsigned CSGAP   = 4;
  localparam int unsigned TIMEOUT = 100;

  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, sclk, cs, di, sdo;
  logic [15:0] rsp_rdata;

  jt9346_ctrl #(.CLKDIV(CLKDIV), .CSGAP(CSGAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sclk(sclk), .cs(cs), .di(di), .sdo(sdo)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] rdata; logic err; int acc; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, rsp_cnt = 0, last_lat = 0, last_rsp_cyc = 0;
  logic last_rsp_cs = 1'b0;

  initial forever begin @(posedge clk); cyc <= cyc + 1; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural EEPROM on the serial pins ----------------
  logic [15:0] ee_mem [64];
  logic        ee_we = 1'b0, force0 = 1'b0, reading = 1'b0, rd_bit = 1'b0;
  logic        cs_p = 1'b0, sclk_p = 1'b0;
  logic [24:0] inshr = '0;
  logic [15:0] rd_word = '0;
  logic [8:0]  last_hdr = '0;
  int busy_cnt = 0, bitn = 0, rdidx = 0;
  int win_rises = 0, last_rises = 0, tot_rises = 0, cs_rise_cnt = 0, last_cs_rise = 0;

  assign sdo = force0 ? 1'b0 : (reading ? rd_bit : (busy_cnt == 0));

  initial forever begin
    @(posedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (cs && !cs_p) begin
      bitn = 0; reading = 1'b0; win_rises = 0; cs_rise_cnt++; last_cs_rise = cyc;
    end
    if (cs && sclk && !sclk_p) begin
      win_rises++; tot_rises++;
      if (reading) begin
        if (rdidx < 16) rd_bit = rd_word[15 - rdidx];
        rdidx++;
      end else begin
        inshr = {inshr[23:0], di};
        bitn++;
        if (bitn == 9) begin
          last_hdr = inshr[8:0];
          if (inshr[8:6] == 3'b110) begin
            reading = 1'b1; rd_bit = 1'b0; rdidx = 0; rd_word = ee_mem[inshr[5:0]];
          end
        end
      end
    end
    if (!cs && cs_p) begin
      last_rises = win_rises;
      reading = 1'b0;
      if (bitn == 9 && inshr[8]) begin
        if (inshr[7:6] == 2'b11 && ee_we) begin
          ee_mem[inshr[5:0]] = 16'hFFFF; busy_cnt = $urandom_range(60, 10);
        end else if (inshr[7:6] == 2'b00) begin
          if (inshr[5:4] == 2'b11) ee_we = 1'b1;
          else if (inshr[5:4] == 2'b00) ee_we = 1'b0;
          else if (inshr[5:4] == 2'b10 && ee_we) begin
            for (int i = 0; i < 64; i++) ee_mem[i] = 16'hFFFF;
            busy_cnt = $urandom_range(60, 10);
          end
        end
      end else if (bitn == 25 && inshr[24] && ee_we) begin
        if (inshr[23:22] == 2'b01) begin
          ee_mem[inshr[21:16]] = inshr[15:0]; busy_cnt = $urandom_range(60, 10);
        end else if (inshr[23:20] == 4'b0001) begin
          for (int i = 0; i < 64; i++) ee_mem[i] = inshr[15:0];
          busy_cnt = $urandom_range(60, 10);
        end
      end
      bitn = 0;
    end
    cs_p = cs; sclk_p = sclk;
  end

  // ---------------- response monitor ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && rsp_valid) begin
      rsp_cnt++; last_rsp_cyc = cyc; last_rsp_cs = cs;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        last_lat = cyc - e.acc + 1;
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // ---------------- word-level reference and stimulus ----------------
  logic [15:0] ref_mem [64];
  logic        ref_we = 1'b0;

  task automatic issue(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d,
                       input bit keep, input bit exp_to);
    exp_t e;
    bit done = 0;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (req_ready) begin
        e.acc = cyc; e.rdata = '0; e.err = exp_to;
        case (op)
          3'd0: e.rdata = ref_mem[a];
          3'd1: if (ref_we) ref_mem[a] = d;
          3'd2: if (ref_we) ref_mem[a] = 16'hFFFF;
          3'd3: ref_we = 1'b1;
          3'd4: ref_we = 1'b0;
          3'd5: if (ref_we) for (int k = 0; k < 64; k++) ref_mem[k] = 16'hFFFF;
          3'd6: if (ref_we) for (int k = 0; k < 64; k++) ref_mem[k] = d;
          default: e.err = 1'b1;
        endcase
        sb.push_back(e);
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    if (!keep) begin @(negedge clk); req_valid = 1'b0; end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) begin done = 1; break; end
    end
    if (!done) chk("rsp_timeout_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int tr, cr, rc, d;
    bit hit;
    logic [5:0]  a;
    logic [15:0] old;
    for (int i = 0; i < 64; i++) begin ee_mem[i] = 16'($urandom); ref_mem[i] = ee_mem[i]; end

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_di", 32'(di), 32'd0);
    rst_n = 1'b1;

    // EWEN, WRITE 0x32, READ back
    issue(3'd3, 6'h00, 16'h0000, 0, 0);
    issue(3'd1, 6'h32, 16'hA5C3, 0, 0);
    issue(3'd0, 6'h32, 16'h0000, 0, 0);
    wait_idle();
    chk("readback_0x32", 32'(rsp_rdata), 32'h0000A5C3);

    // READ 0x2A: header bits, rise count, single cs window, latency
    cr = cs_rise_cnt;
    issue(3'd0, 6'h2A, 16'h0000, 0, 0);
    wait_idle();
    chk("read_hdr_bits", 32'(last_hdr), 32'({1'b1, 2'b10, 6'h2A}));
    chk("read_sclk_rises", 32'(last_rises), 32'd25);
    chk("read_cs_windows", 32'(cs_rise_cnt - cr), 32'd1);
    chk("read_latency", 32'(last_lat), 32'(1 + CLKDIV + 25 * 2 * CLKDIV + CSGAP + 1));

    // WRITE with sdo stuck low: busy timeout
    force0 = 1'b1;
    issue(3'd1, 6'(($urandom)), 16'($urandom), 0, 1);
    wait_idle();
    force0 = 1'b0;
    d = last_rsp_cyc - last_cs_rise;
    chk("timeout_latency_in_range", 32'(d >= int'(TIMEOUT) && d <= int'(TIMEOUT + CSGAP + 6)), 32'd1);
    chk("timeout_cs_low_at_rsp", 32'(last_rsp_cs), 32'd0);

    // reserved op
    tr = tot_rises; cr = cs_rise_cnt;
    issue(3'd7, 6'h15, 16'h1234, 0, 0);
    wait_idle();
    chk("rsvd_latency", 32'(last_lat), 32'd2);
    chk("rsvd_no_sclk", 32'(tot_rises - tr), 32'd0);
    chk("rsvd_no_cs", 32'(cs_rise_cnt - cr), 32'd0);

    // reset during 5th sclk period of a WRITE
    a = 6'($urandom); old = ref_mem[a];
    issue(3'd1, a, ~old, 0, 0);
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cs && !sclk && win_rises == 4) begin hit = 1; break; end
    end
    chk("abort_point_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'd0);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_di", 32'(di), 32'd0);
    void'(sb.pop_back());
    ref_mem[a] = old;
    rc = rsp_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt - rc), 32'd0);
    issue(3'd3, 6'h00, 16'h0000, 0, 0);
    issue(3'd0, a, 16'h0000, 0, 0);
    wait_idle();
    chk("abort_old_data", 32'(rsp_rdata), 32'(old));

    // req_valid held high across three requests
    rc = rsp_cnt;
    a = 6'($urandom);
    issue(3'd0, a ^ 6'h01, 16'h0000, 1, 0);
    issue(3'd1, a, 16'($urandom), 1, 0);
    issue(3'd0, a, 16'h0000, 0, 0);
    wait_idle();
    chk("held_valid_rsp_count", 32'(rsp_cnt - rc), 32'd3);

    // randomized mix
    for (int n = 0; n < 16; n++)
      issue(3'($urandom_range(7, 0)), 6'($urandom), 16'($urandom), 0, 0);
    wait_idle();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
